// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches words over a req/ready handshake and
// selects the next PC from the decoders' branch/jump controls and the ALU zero flag.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      imem_addr,
  output logic             imem_req,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  output logic [31:0]      instr,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic             instr_valid,
  output logic [31:0]      pcplus4,
  input  logic [1:0]       branch,
  input  logic             jump,
  input  logic             zero,
  input  logic             exec_done,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic {FETCH, EXEC} state_t;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_t           r_state;
  state_t           w_nextState;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic [CNT_W-1:0] r_retired;
  logic [31:0]      w_pcPlus4;
  logic [31:0]      w_branchOffset;
  logic [31:0]      w_branchTarget;
  logic [31:0]      w_jumpTarget;
  logic [31:0]      w_nextPc;
  logic             w_branchTaken;
  logic             w_fetchDone;
  logic             w_execDone;

  assign w_fetchDone = (r_state == FETCH) && imem_ready;
  assign w_execDone  = (r_state == EXEC) && exec_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      FETCH:   if (imem_ready) w_nextState = EXEC;
      EXEC:    if (exec_done)  w_nextState = FETCH;
      default: w_nextState = FETCH;
    endcase
  end

  // Handshake outputs are gated by reset so memory sees no request while it is held.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (r_state)
      FETCH:   imem_req    = !reset;
      EXEC:    instr_valid = !reset;
      default: begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
      end
    endcase
  end

  assign w_pcPlus4      = r_pc + 32'd4;
  assign w_branchOffset = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_branchTarget = w_pcPlus4 + w_branchOffset;
  assign w_jumpTarget   = {w_pcPlus4[31:28], r_instr[25:0], 2'b00};
  assign w_branchTaken  = branch[1] && (zero ^ branch[0]);

  // Jump outranks a taken branch; anything else falls through to the sequential PC.
  always_comb begin
    w_nextPc = w_pcPlus4;
    if (jump) begin
      w_nextPc = w_jumpTarget;
    end else if (w_branchTaken) begin
      w_nextPc = w_branchTarget;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_instr   <= 32'h0;
      r_retired <= '0;
    end else begin
      if (w_fetchDone) begin
        r_instr <= imem_rdata;
      end
      if (w_execDone) begin
        r_pc      <= w_nextPc;
        r_retired <= r_retired + CntOne;
      end
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign pcplus4   = w_pcPlus4;
  assign instr     = r_instr;
  assign op        = r_instr[31:26];
  assign funct     = r_instr[5:0];
  assign retired   = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, randomized instruction
// stream against an arithmetic next-PC model, and reset-in-flight sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pcplus4;
  logic [1:0]  branch;
  logic        jump;
  logic        zero;
  logic        exec_done;
  logic [31:0] pc;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  logic [31:0] modelPc;
  logic [31:0] modelInstr;
  logic [31:0] modelRetired;

  typedef struct {
    logic [31:0] rdata;
    int          waits;
    int          stalls;
    logic [1:0]  br;
    logic        j;
    logic        z;
    logic [31:0] expPc;
  } vec_t;

  vec_t vecs[18];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .instr(instr), .op(op), .funct(funct), .instr_valid(instr_valid),
    .pcplus4(pcplus4), .branch(branch), .jump(jump), .zero(zero),
    .exec_done(exec_done), .pc(pc), .retired(retired)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Next PC straight from the architectural rules, using plain integer arithmetic.
  function automatic logic [31:0] refNextPc(input logic [31:0] curPc, input logic [31:0] iw,
                                            input logic [1:0] br, input logic j, input logic z);
    logic [31:0] seq;
    int          offsetBytes;
    seq = curPc + 32'd4;
    if (j) return (seq & 32'hF000_0000) + (iw & 32'h03FF_FFFF) * 32'd4;
    if (br[1] && (z != br[0])) begin
      offsetBytes = int'($signed(iw[15:0])) * 4;
      return seq + $unsigned(offsetBytes);
    end
    return seq;
  endfunction

  // One full instruction: fetch with wait states, optional EXEC stall, then retire.
  task automatic applyStimulus(input logic [31:0] rdata, input int waits, input int stalls,
                               input logic [1:0] br, input logic j, input logic z);
    checkOutput("fetchReq", {31'b0, imem_req}, 32'd1);
    checkOutput("fetchAddr", imem_addr, modelPc);
    for (int w = 0; w < waits; w++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      exec_done  = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("waitReq", {31'b0, imem_req}, 32'd1);
      checkOutput("waitInstrHold", instr, modelInstr);
      checkOutput("waitValid", {31'b0, instr_valid}, 32'd0);
      checkOutput("waitPc", pc, modelPc);
    end
    imem_ready = 1'b1;
    imem_rdata = rdata;
    exec_done  = 1'($urandom_range(0, 1));
    @(negedge clk);
    modelInstr = rdata;
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    checkOutput("execValid", {31'b0, instr_valid}, 32'd1);
    checkOutput("execReq", {31'b0, imem_req}, 32'd0);
    checkOutput("execInstr", instr, modelInstr);
    checkOutput("execOp", {26'b0, op}, {26'b0, modelInstr[31:26]});
    checkOutput("execFunct", {26'b0, funct}, {26'b0, modelInstr[5:0]});
    checkOutput("execPcPlus4", pcplus4, modelPc + 32'd4);
    for (int s = 0; s < stalls; s++) begin
      exec_done  = 1'b0;
      imem_ready = 1'($urandom_range(0, 1));
      branch     = 2'($urandom_range(0, 3));
      jump       = 1'($urandom_range(0, 1));
      zero       = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("stallValid", {31'b0, instr_valid}, 32'd1);
      checkOutput("stallInstr", instr, modelInstr);
      checkOutput("stallPc", pc, modelPc);
    end
    exec_done  = 1'b1;
    imem_ready = 1'($urandom_range(0, 1));
    branch     = br;
    jump       = j;
    zero       = z;
    @(negedge clk);
    modelPc      = refNextPc(modelPc, modelInstr, br, j, z);
    modelRetired = modelRetired + 32'd1;
    exec_done  = 1'b0;
    imem_ready = 1'b0;
    checkOutput("nextPc", pc, modelPc);
    checkOutput("retired", retired, modelRetired);
    checkOutput("backInFetch", {31'b0, imem_req}, 32'd1);
    checkOutput("fetchValidLow", {31'b0, instr_valid}, 32'd0);
    checkOutput("instrHeld", instr, modelInstr);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs = '{
      '{32'h0000_0000, 0, 0, 2'b00, 1'b0, 1'b0, 32'h0000_0004},
      '{32'h0000_0000, 0, 0, 2'b00, 1'b0, 1'b0, 32'h0000_0008},
      '{32'h0000_0000, 0, 0, 2'b00, 1'b0, 1'b0, 32'h0000_000C},
      '{32'h0000_0000, 0, 0, 2'b00, 1'b0, 1'b0, 32'h0000_0010},
      '{32'h2009_0005, 5, 0, 2'b00, 1'b0, 1'b0, 32'h0000_0014},
      '{32'h0800_0008, 0, 0, 2'b00, 1'b1, 1'b0, 32'h0000_0020},
      '{32'h1000_FFFE, 0, 0, 2'b10, 1'b0, 1'b1, 32'h0000_001C},
      '{32'h0800_0008, 0, 0, 2'b00, 1'b1, 1'b0, 32'h0000_0020},
      '{32'h1000_FFFE, 1, 2, 2'b10, 1'b0, 1'b0, 32'h0000_0024},
      '{32'h0800_0010, 0, 0, 2'b10, 1'b1, 1'b1, 32'h0000_0040},
      '{32'h1400_0003, 0, 0, 2'b11, 1'b0, 1'b0, 32'h0000_0050},
      '{32'h0800_0010, 0, 0, 2'b00, 1'b1, 1'b0, 32'h0000_0040},
      '{32'h1400_0003, 0, 1, 2'b11, 1'b0, 1'b1, 32'h0000_0044},
      '{32'h1000_FFEC, 0, 0, 2'b10, 1'b0, 1'b1, 32'hFFFF_FFF8},
      '{32'h0800_0010, 0, 0, 2'b10, 1'b1, 1'b1, 32'hF000_0040},
      '{32'h0BFF_FFFF, 0, 0, 2'b00, 1'b1, 1'b0, 32'hFFFF_FFFC},
      '{32'h0000_0000, 0, 0, 2'b00, 1'b0, 1'b0, 32'h0000_0000},
      '{32'h1000_0005, 0, 0, 2'b01, 1'b0, 1'b0, 32'h0000_0004}
    };

    reset      = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    branch     = 2'b00;
    jump       = 1'b0;
    zero       = 1'b0;
    exec_done  = 1'b1;
    modelPc      = 32'h0;
    modelInstr   = 32'h0;
    modelRetired = 32'h0;

    // Reset held for three cycles with ready/done high; nothing may move.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("rstPc", pc, 32'h0);
      checkOutput("rstReq", {31'b0, imem_req}, 32'd0);
      checkOutput("rstValid", {31'b0, instr_valid}, 32'd0);
      checkOutput("rstRetired", retired, 32'h0);
      checkOutput("rstInstr", instr, 32'h0);
    end
    imem_ready = 1'b0;
    exec_done  = 1'b0;
    reset      = 1'b0;
    #1;
    checkOutput("relReq", {31'b0, imem_req}, 32'd1);
    checkOutput("relAddr", imem_addr, 32'h0);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].rdata, vecs[i].waits, vecs[i].stalls, vecs[i].br, vecs[i].j, vecs[i].z);
      checkOutput($sformatf("tablePc[%0d]", i), pc, vecs[i].expPc);
      checkOutput($sformatf("tableRetired[%0d]", i), retired, 32'(i + 1));
    end

    for (int r = 0; r < 40; r++) begin
      applyStimulus($urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                    2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    // Reset arriving mid-EXEC must clear state asynchronously and restart at RESET_PC.
    imem_ready = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ready = 1'b0;
    checkOutput("midExecValid", {31'b0, instr_valid}, 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("midRstPc", pc, 32'h0);
    checkOutput("midRstValid", {31'b0, instr_valid}, 32'd0);
    checkOutput("midRstInstr", instr, 32'h0);
    checkOutput("midRstRetired", retired, 32'h0);
    checkOutput("midRstReq", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    reset        = 1'b0;
    modelPc      = 32'h0;
    modelInstr   = 32'h0;
    modelRetired = 32'h0;
    #1;
    checkOutput("midRelAddr", imem_addr, 32'h0);
    applyStimulus(32'h0000_0000, 1, 0, 2'b00, 1'b0, 1'b0);
    checkOutput("afterRstPc", pc, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
